// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver, with a sticky overflow flag.
// Define UART_RX_FIFO_WATERMARK_EN to build the almost_full comparator (otherwise tied to 0).
module uart_rx_fifo #(
    parameter int D_BITS      = 8,
    parameter int ADDR_W      = 4,
    parameter int ALMOST_FULL = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_tick,
    input  logic [D_BITS-1:0] wr_data,
    input  logic              rd_ready,
    input  logic              ovf_clr,
    output logic [D_BITS-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              almost_full
);

    localparam int DEPTH = 1 << ADDR_W;

    if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_af_range
        $error("uart_rx_fifo: ALMOST_FULL out of range 1..2^ADDR_W");
    end

    logic [D_BITS-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              pop;
    logic              push;
    logic              drop;

    // Extra pointer MSB separates full (wrapped once) from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                      (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign count    = wr_ptr - rd_ptr;
    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr[ADDR_W-1:0]];

    // A pop frees the slot the same cycle, so a full FIFO can still accept a write.
    assign pop  = rd_valid & rd_ready;
    assign push = wr_tick & (!full | pop);
    assign drop = wr_tick & full & !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_WATERMARK_EN
    localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W+1)'(ALMOST_FULL);
    assign almost_full = (count >= AF_LEVEL);
`else
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fifo;

    localparam int D_BITS = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int AF     = 12;

    logic              clk;
    logic              reset_n;
    logic              wr_tick;
    logic [D_BITS-1:0] wr_data;
    logic              rd_ready;
    logic              ovf_clr;
    logic [D_BITS-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              almost_full;

    uart_rx_fifo #(.D_BITS(D_BITS), .ADDR_W(ADDR_W), .ALMOST_FULL(AF)) dut (
        .clk(clk), .reset_n(reset_n), .wr_tick(wr_tick), .wr_data(wr_data),
        .rd_ready(rd_ready), .ovf_clr(ovf_clr), .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .full(full), .count(count), .overflow(overflow),
        .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    bit         chk_en = 1'b0;
    int         max_cnt_pairs = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_af(input int n);
`ifdef UART_RX_FIFO_WATERMARK_EN
        return (n >= AF) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Reference model: apply one clock edge's worth of FIFO rules to the queue.
    task automatic model_edge();
        bit was_full;
        bit do_pop;
        was_full = (q.size() == DEPTH);
        do_pop   = (q.size() > 0) && rd_ready;
        if (do_pop) void'(q.pop_front());
        if (wr_tick) begin
            if (!was_full || do_pop) q.push_back(wr_data);
            else m_ovf = 1'b1;
        end
        if (!(wr_tick && was_full && !do_pop) && ovf_clr) m_ovf = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_tick = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0; wr_data = '0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_tick = 1'b1; wr_data = d; tick(); wr_tick = 1'b0;
    endtask

    task automatic pop_one();
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    endtask

    task automatic drain_all();
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        rd_ready = 1'b0;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            chk("rd_valid", int'(rd_valid), int'(q.size() > 0));
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("full", int'(full), int'(q.size() == DEPTH));
            chk("count", int'(count), q.size());
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("almost_full", int'(almost_full), exp_af(q.size()));
            if (q.size() > 0) chk("rd_data", int'(rd_data), int'(q[0]));
        end
    end

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_almost_full", int'(almost_full), 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Single byte round trip
        push_byte(8'hA5);
        chk("t1_valid", int'(rd_valid), 1);
        chk("t1_data", int'(rd_data), 8'hA5);
        chk("t1_count", int'(count), 1);
        chk("t1_empty", int'(empty), 0);
        pop_one();
        chk("t1_empty_after", int'(empty), 1);
        chk("t1_count_after", int'(count), 0);

        // Fill, overflow, ordered readback
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("t2_full", int'(full), 1);
        chk("t2_count", int'(count), 16);
        push_byte(8'hFF);
        chk("t2_overflow", int'(overflow), 1);
        chk("t2_count_ovf", int'(count), 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_readback", int'(rd_data), i);
            pop_one();
        end
        chk("t2_empty", int'(empty), 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t2_ovf_cleared", int'(overflow), 0);

        // Simultaneous write and pop while full
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
        wr_tick = 1'b1; wr_data = 8'h55; rd_ready = 1'b1; tick();
        wr_tick = 1'b0; rd_ready = 1'b0;
        chk("t3_count", int'(count), 16);
        chk("t3_overflow", int'(overflow), 0);
        chk("t3_head", int'(rd_data), 8'h11);
        for (int i = 0; i < 15; i++) pop_one();
        chk("t3_last", int'(rd_data), 8'h55);
        pop_one();
        chk("t3_empty", int'(empty), 1);

        // Pointer wrap with interleaved push/pop
        for (int k = 0; k < 40; k++) begin
            push_byte(8'(8'h80 + k));
            if (int'(count) > max_cnt_pairs) max_cnt_pairs = int'(count);
            chk("t4_data", int'(rd_data), (8'h80 + k) & 8'hFF);
            pop_one();
        end
        chk("t4_max_count", max_cnt_pairs, 1);
        chk("t4_empty", int'(empty), 1);

        // Overflow set wins over coincident clear
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        push_byte(8'hEE);
        chk("t5_ovf_set", int'(overflow), 1);
        wr_tick = 1'b1; wr_data = 8'hDD; ovf_clr = 1'b1; tick();
        wr_tick = 1'b0; ovf_clr = 1'b0;
        chk("t5_ovf_hold", int'(overflow), 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t5_ovf_clr", int'(overflow), 0);
        drain_all();

        // Watermark crossing
        for (int i = 0; i < 12; i++) begin
            push_byte(8'(i));
`ifdef UART_RX_FIFO_WATERMARK_EN
            chk("t6_af_rise", int'(almost_full), (i == 11) ? 1 : 0);
`else
            chk("t6_af_tied", int'(almost_full), 0);
`endif
        end
        pop_one();
        chk("t6_af_fall", int'(almost_full), 0);
        chk("t6_count11", int'(count), 11);

        // Asynchronous reset mid-operation
        @(posedge clk);
        model_edge();
        #3;
        reset_n = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_rd_data", int'(rd_data), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            wr_tick  = ($urandom_range(0, 99) < 55);
            wr_data  = 8'($urandom);
            rd_ready = ($urandom_range(0, 99) < 45);
            ovf_clr  = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle_inputs();
        tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
